// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone B3 incrementing-burst master. A command (direction, start byte
//   address, beat count minus one) is accepted in IDLE. The burst then runs
//   in ACTIVE until its final beat is acked, the slave signals err/rty, or a
//   stalled beat times out. DONE then reports completion for one cycle.
//
//   state  | meaning
//   IDLE   | ready for a command, bus released
//   ACTIVE | cycle open, issuing beats
//   DONE   | one-cycle completion report (done_o, err_o)
//
// Ports
//   wb_clk_i, wb_rst_n_i        clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_we_i, cmd_adr_i, cmd_len_i  direction, start address, beats-1
//   wr_dat_i/wr_valid_i/wr_ready_o  write word stream
//   rd_dat_o/rd_valid_o         read word strobe (no backpressure)
//   done_o, err_o, busy_o       completion pulse, error status, busy
//   wbm_*_o / wbm_*_i           Wishbone B3 master port
module wb_burst_master #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int tmo_cycles = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [7:0]    cmd_len_i,
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic          busy_o,
  output logic [aw-1:0] wbm_adr_o,
  output logic [1:0]    wbm_bte_o,
  output logic [2:0]    wbm_cti_o,
  output logic          wbm_cyc_o,
  output logic [dw-1:0] wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i,
  input  logic [dw-1:0] wbm_dat_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  localparam logic [aw-1:0] ADR_STEP  = aw'(dw / 8);
  localparam logic [aw-1:0] ADR_ALIGN = aw'(3);
  localparam logic [15:0]   TMO_LAST  = 16'(tmo_cycles - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [7:0]      r_rem;      // beats remaining after the current one
  logic [aw-1:0]   r_adr;
  logic [15:0]     r_tmo;
  logic            r_err;
  logic [dw-1:0]   r_rd_dat;
  logic            r_rd_valid;

  logic            w_active;
  logic            w_stb;
  logic            w_no_resp;
  logic            w_ack_ok;
  logic            w_tmo_hit;
  logic            w_fail;
  logic            w_last;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = (r_state == S_ACTIVE);
    w_stb       = w_active & (r_we ? wr_valid_i : 1'b1);
    w_no_resp   = ~wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
    // error/retry take priority over a simultaneous ack
    w_ack_ok    = w_stb & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
    w_tmo_hit   = w_stb & w_no_resp & (r_tmo == TMO_LAST);
    w_fail      = (w_stb & (wbm_err_i | wbm_rty_i)) | w_tmo_hit;
    w_last      = (r_rem == 8'd0);

    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_sel_o   = 4'h0;
    wbm_cti_o   = 3'b000;
    wbm_bte_o   = 2'b00;
    wbm_adr_o   = r_adr;
    wbm_dat_o   = wr_dat_i;
    wr_ready_o  = w_ack_ok & r_we;
    rd_dat_o    = r_rd_dat;
    rd_valid_o  = r_rd_valid;

    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = w_stb;
        wbm_we_o  = r_we;
        wbm_sel_o = 4'hF;
        wbm_cti_o = w_last ? 3'b111 : 3'b010;
        if (w_fail || (w_ack_ok && w_last)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        err_o       = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_we       <= 1'b0;
      r_rem      <= 8'd0;
      r_adr      <= '0;
      r_tmo      <= 16'd0;
      r_err      <= 1'b0;
      r_rd_dat   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_ack_ok & ~r_we;
      if (w_ack_ok && !r_we) r_rd_dat <= wbm_dat_i;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_we  <= cmd_we_i;
            r_rem <= cmd_len_i;
            r_adr <= cmd_adr_i & ~ADR_ALIGN;
            r_tmo <= 16'd0;
            r_err <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_fail) r_err <= 1'b1;
          if (w_ack_ok) begin
            r_adr <= r_adr + ADR_STEP;
            r_rem <= r_rem - 8'd1;
            r_tmo <= 16'd0;
          end else if (w_stb && w_no_resp) begin
            // stb low (write underrun) leaves the counter untouched
            r_tmo <= r_tmo + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;
  localparam int TMO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic [31:0] wr_dat_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] rd_dat_o;
  logic        rd_valid_o;
  logic        done_o, err_o, busy_o;
  logic [31:0] wbm_adr_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o, wbm_we_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [31:0] wbm_dat_i;

  // slave model controls
  bit slave_on = 0, stray_ack = 0, force_ack = 0, force_err = 0;
  int err_beat = -1, err_kind = 0, beat_idx = 0;
  logic w_hit;

  assign w_hit     = wbm_cyc_o & wbm_stb_o & (beat_idx == err_beat);
  assign wbm_ack_i = (slave_on & wbm_cyc_o & wbm_stb_o) | (stray_ack & wbm_cyc_o & ~wbm_stb_o) | force_ack;
  assign wbm_err_i = (w_hit & (err_kind == 1)) | force_err;
  assign wbm_rty_i = w_hit & (err_kind == 2);
  assign wbm_dat_i = wbm_adr_o ^ 32'h5A5A_0000;

  wb_burst_master #(.dw(32), .aw(32), .tmo_cycles(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wr_dat_i(wr_dat_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .wbm_adr_o(wbm_adr_o), .wbm_bte_o(wbm_bte_o), .wbm_cti_o(wbm_cti_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [7:0]  len;
    int          gap;       // idle write-valid cycles between words
    bit          stray;     // slave acks while stb is low
    bit          silent;    // slave never responds
    int          err_beat;  // beat index that gets err/rty, -1 none
    int          err_kind;  // 1 err, 2 rty
    logic [31:0] exp_adr0;
    int          exp_beats; // beats completed without error
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int beats = 0, rd_cnt = 0, wr_cnt = 0, stalls = 0, tmo_cnt = 0, gap_cnt = 0;
    bit prev_rd_ack = 0, done_seen = 0, acc;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat_q[$];

    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_len_i = v.len;
    slave_on = !v.silent; stray_ack = v.stray; err_beat = v.err_beat;
    err_kind = v.err_kind; beat_idx = 0; wr_valid_i = 1'b0;
    @(negedge wb_clk_i);
    chk("cmd_ready idle", cmd_ready_o, 1);
    @(posedge wb_clk_i); #1;
    exp_adr = v.exp_adr0;

    for (int c = 0; c < 100 && !done_seen; c++) begin
      beat_idx = beats;
      if (v.we) begin
        wr_dat_i = 32'hD000_0000 + 32'(beats);
        if (gap_cnt > 0) begin wr_valid_i = 1'b0; gap_cnt--; end
        else wr_valid_i = 1'b1;
      end
      @(negedge wb_clk_i);
      chk("rd_valid timing", rd_valid_o, prev_rd_ack);
      if (rd_valid_o && prev_rd_ack && exp_dat_q.size() > 0) begin
        chk("rd_dat", rd_dat_o, exp_dat_q.pop_front());
        rd_cnt++;
      end
      prev_rd_ack = 0;
      if (wr_ready_o) wr_cnt++;
      if (done_o) begin
        done_seen = 1;
        chk("done err", err_o, v.exp_err);
        chk("done cyc", wbm_cyc_o, 0);
        chk("done stb", wbm_stb_o, 0);
        chk("done wr_ready", wr_ready_o, 0);
        chk("beats", beats, v.exp_beats);
        cmd_valid_i = 1'b0;
      end else begin
        chk("cyc", wbm_cyc_o, 1);
        chk("cmd_ready busy", cmd_ready_o, 0);
        chk("we", wbm_we_o, v.we);
        chk("sel/bte", {wbm_sel_o, wbm_bte_o}, {4'hF, 2'b00});
        chk("adr", wbm_adr_o, exp_adr);
        chk("cti", wbm_cti_o, (beats == int'(v.len)) ? 3'b111 : 3'b010);
        if (v.we && wbm_stb_o) chk("wr dat", wbm_dat_o, 32'hD000_0000 + 32'(beats));
        if (!wbm_stb_o) stalls++;
        if (wbm_stb_o && !wbm_ack_i && !wbm_err_i && !wbm_rty_i) tmo_cnt++;
        acc = wbm_stb_o & wbm_ack_i & !wbm_err_i & !wbm_rty_i;
        chk("wr_ready", wr_ready_o, v.we & acc);
        if (acc) begin
          if (!v.we) begin
            exp_dat_q.push_back(exp_adr ^ 32'h5A5A_0000);
            prev_rd_ack = 1;
          end
          exp_adr = exp_adr + 32'd4;
          beats++;
          if (v.we) gap_cnt = v.gap;
        end
      end
      @(posedge wb_clk_i); #1;
    end
    cmd_valid_i = 1'b0;
    wr_valid_i = 1'b0;
    if (!done_seen) chk("done within budget", 0, 1);
    @(negedge wb_clk_i);
    chk("post done_o", done_o, 0);
    chk("post busy", busy_o, 0);
    chk("post cmd_ready", cmd_ready_o, 1);
    if (!v.we) chk("rd pulses", rd_cnt, v.exp_beats);
    else chk("wr_ready pulses", wr_cnt, v.exp_beats);
    if (v.we && !v.exp_err) chk("stall cycles", stalls, v.gap * (v.exp_beats - 1));
    if (v.silent) chk("timeout cycles", tmo_cnt, TMO);
  endtask

  vec_t vecs[8];
  bit   saw_done;

  initial begin
    //          we adr           len  gap str sil eb kind  exp_adr0      beats err
    vecs[0] = '{0, 32'h0000_0103, 8'd3, 0, 0, 0, -1, 0, 32'h0000_0100, 4, 0};
    vecs[1] = '{1, 32'h0000_0200, 8'd1, 3, 1, 0, -1, 0, 32'h0000_0200, 2, 0};
    vecs[2] = '{0, 32'h0000_0040, 8'd0, 0, 0, 0, -1, 0, 32'h0000_0040, 1, 0};
    vecs[3] = '{0, 32'h0000_0103, 8'd3, 0, 0, 0,  1, 1, 32'h0000_0100, 1, 1};
    vecs[4] = '{0, 32'h0000_0300, 8'd5, 0, 0, 1, -1, 0, 32'h0000_0300, 0, 1};
    vecs[5] = '{1, 32'hFFFF_FFF8, 8'd3, 0, 0, 0, -1, 0, 32'hFFFF_FFF8, 4, 0};
    vecs[6] = '{1, 32'h0000_0500, 8'd2, 0, 0, 0,  2, 2, 32'h0000_0500, 2, 1};
    vecs[7] = '{0, 32'h0000_1002, 8'd7, 0, 0, 0, -1, 0, 32'h0000_1000, 8, 0};

    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst cyc/stb/we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
    chk("rst adr", wbm_adr_o, 0);
    chk("rst cti/bte/sel", {wbm_cti_o, wbm_bte_o, wbm_sel_o}, 0);
    chk("rst rd", {rd_valid_o, rd_dat_o}, 0);
    chk("rst done/err/wr_ready/busy", {done_o, err_o, wr_ready_o, busy_o}, 0);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    chk("rst cmd_ready", cmd_ready_o, 1);

    // stray responses while the bus is idle must be ignored
    force_ack = 1; force_err = 1;
    @(negedge wb_clk_i);
    force_ack = 0; force_err = 0;
    @(negedge wb_clk_i);
    chk("idle resp ignored", {done_o, err_o, rd_valid_o, busy_o}, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset during beat 3 of an 8-beat read
    slave_on = 1; stray_ack = 0; err_beat = -1; err_kind = 0;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h0000_0800; cmd_len_i = 8'd7;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    wb_rst_n_i = 1'b0;
    @(negedge wb_clk_i);
    chk("beat3 adr", wbm_adr_o, 32'h0000_0808);
    chk("beat3 cyc", wbm_cyc_o, 1);
    @(posedge wb_clk_i); #1;
    chk("mid rst cyc/stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    saw_done = done_o;
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      saw_done = saw_done | done_o;
    end
    chk("mid rst no done", saw_done, 0);
    chk("mid rst idle", {busy_o, cmd_ready_o, wbm_cyc_o}, 3'b010);
    chk("mid rst cmd discarded adr", wbm_adr_o, 0);

    // a fresh command runs normally after the aborted one
    run_vec(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameters (one per line: name, default, meaning): dw, 32, Wishbone data width; aw, 32, Wishbone address width; tmo_cycles, 1024, stalled-beat timeout in cycles (16-bit counter).
REQ-002 wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-003 wb_rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  in  1  command request; cmd_ready_o  out  1  command accepted when both high.
REQ-005 cmd_we_i  in  1  1=write burst, 0=read burst; cmd_adr_i  in  aw  start byte address; cmd_len_i  in  8  beats minus one (0 -> 1 beat, 255 -> 256 beats).
REQ-006 wr_dat_i  in  dw  write data; wr_valid_i  in  1  write word available; wr_ready_o  out  1  write word consumed this cycle.
REQ-007 rd_dat_o  out  dw  read data; rd_valid_o  out  1  one-cycle read word strobe, no backpressure.
REQ-008 done_o  out  1  one-cycle command-complete pulse; err_o  out  1  error status, valid only with done_o; busy_o  out  1  command in progress.
REQ-009 wbm_adr_o aw, wbm_bte_o 2, wbm_cti_o 3, wbm_cyc_o 1, wbm_dat_o dw, wbm_sel_o 4, wbm_stb_o 1, wbm_we_o 1 -- out, Wishbone B3 master signals.
REQ-010 wbm_ack_i 1, wbm_err_i 1, wbm_rty_i 1, wbm_dat_i dw -- in, Wishbone B3 slave responses.

Function
REQ-011 States IDLE, ACTIVE, DONE; busy_o = (state != IDLE); cmd_ready_o = (state == IDLE).
REQ-012 IDLE: on cmd_valid_i & cmd_ready_o capture we, len, adr with adr[1:0] forced to 0; enter ACTIVE next cycle with wbm_cyc_o=1.
REQ-013 ACTIVE: wbm_sel_o=4'hF, wbm_bte_o=2'b00 (linear), wbm_we_o=captured we, wbm_cyc_o=1.
REQ-014 wbm_cti_o=3'b010 while beats remaining after current > 0, 3'b111 on final beat (including 1-beat commands).
REQ-015 Read: wbm_stb_o=1 every ACTIVE cycle; each ack registers wbm_dat_i to rd_dat_o and pulses rd_valid_o the following cycle.
REQ-016 Write: wbm_stb_o=wr_valid_i, wbm_dat_o=wr_dat_i; wr_ready_o = wbm_ack_i & wbm_stb_o & ACTIVE & we; stb low stalls burst with adr and cti held.
REQ-017 On each accepted ack (cyc & stb & ack & !err & !rty): wbm_adr_o += dw/8, remaining count -= 1; address wraps modulo 2^aw.
REQ-018 Ack on final beat: cyc and stb low next cycle, enter DONE; DONE drives done_o=1, err_o=0 for one cycle, then IDLE.
REQ-019 wbm_err_i or wbm_rty_i while cyc & stb: abort; no rd_valid_o/wr_ready_o for that beat; cyc low next cycle; DONE with err_o=1.
REQ-020 err/rty together with ack: error wins.
REQ-021 Responses while stb or cyc low are ignored.
REQ-022 Timeout counter cleared on ACTIVE entry and each ack; increments on cycles with stb high and no response; holds while stb low; reaching tmo_cycles aborts as REQ-019.
REQ-023 No new command accepted in ACTIVE or DONE; back-to-back commands have one IDLE cycle minimum between bursts.

Reset
REQ-024 With wb_rst_n_i low at a rising edge: state IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=0, wbm_cti_o=0, wbm_bte_o=0, wbm_sel_o=0, rd_valid_o=0, rd_dat_o=0, done_o=0, err_o=0, wr_ready_o=0, busy_o=0, cmd_ready_o=1 after reset releases.
REQ-025 Reset mid-burst: cyc/stb low at that edge, no done_o pulse, captured command discarded.

Verification
REQ-026 Read cmd_adr 0x103, len 3, ack every cycle -> adr 0x100,0x104,0x108,0x10C; cti 010,010,010,111; four rd_valid_o pulses each one cycle after ack; done_o=1, err_o=0 one cycle after cyc drops.
REQ-027 Write len 1, wr_valid_i low 3 cycles between words -> stb low 3 cycles, adr and cti=010 held, two wr_ready_o pulses, final cti 111, done_o err_o=0.
REQ-028 Read len 0 -> single beat cti 111, one rd_valid_o, done_o.
REQ-029 Read len 3, wbm_err_i on beat 2 (with ack) -> one rd_valid_o only, cyc low next cycle, done_o=1 err_o=1.
REQ-030 tmo_cycles=8, slave never responds -> abort after 8 stb cycles, done_o=1 err_o=1, next command accepted.
REQ-031 wb_rst_n_i low during beat 3 of 8 -> cyc low next edge, no done_o, cmd_ready_o=1 after release.
